temp_zone_encoder: RTL and testbench
====================================

// Module: temp_zone_encoder
// PURPOSE
//  Source end of the two-bit temperature code {Temperatura1,Temperatura2} that
//  the board top-level decodes onto LED[7]/LED[6]/SEG[7]. Accepts strobed 8-bit
//  temperature samples and classifies each one into a zone, with hysteresis and a
//  consecutive-sample stability filter. Drives the registered zone code, a valid
//  flag and a change pulse. Sits between the sample source (SWI or a sensor reader)
//  and the alarm decoder.
// PARAMETERS
//  NBITS      8    sample width (unsigned)
//  T_LOW      20   COLD/NORMAL boundary
//  T_HIGH     40   NORMAL/HOT boundary
//  HYST       2    hysteresis margin; legal iff HYST<=T_LOW, T_LOW+HYST<T_HIGH-HYST,
//                  T_HIGH+HYST<2**NBITS-1
//  STABLE_CNT 4    consecutive identical candidate samples needed to move (>=1)
// PORTS
//  clk_2        in   1      clock; all state updates on the rising edge
//  reset        in   1      asynchronous, active-low reset
//  temp_in      in   NBITS  temperature sample, qualified by sample_valid
//  sample_valid in   1      one-cycle strobe; temp_in is consumed when it is 1
//  temp_code    out  2      {Temperatura1,Temperatura2}: 00 COLD, 01 NORMAL,
//                           11 HOT, 10 FAULT
//  code_valid   out  1      1 after the first committed zone, held until reset
//  zone_change  out  1      one-cycle pulse coinciding with each temp_code update
//  alarm        out  1      only with TEMP_ALARM_LATCH_EN (see CONFIGURATION)
//  alarm_clr    in   1      only with TEMP_ALARM_LATCH_EN
// BEHAVIOUR
//  Reset (reset=0, any time):
//   - zone=COLD, temp_code=00, code_valid=0, zone_change=0, alarm=0.
//   - Pending candidate and counter cleared; in-progress filtering is discarded.
//  Idle cycles: sample_valid=0 leaves all state unchanged; zone_change=0.
//  Candidate, computed per accepted sample. Rising limits use T+HYST, falling
//  limits use T-HYST:
//   - temp_in == all-ones                      -> FAULT
//   - from COLD:   >=T_HIGH+HYST HOT;  >=T_LOW+HYST NORMAL;  else COLD
//   - from NORMAL: >=T_HIGH+HYST HOT;  <T_LOW-HYST COLD;     else NORMAL
//   - from HOT:    <T_LOW-HYST COLD;   <T_HIGH-HYST NORMAL;  else HOT
//   - from FAULT:  no hysteresis: >=T_HIGH HOT; >=T_LOW NORMAL; else COLD
//   - code_valid=0 (first sample ever): classified as from FAULT
//  Filter / commit:
//   - First sample after reset: commits immediately, no filter.
//   - Candidate FAULT: commits immediately, no filter.
//   - Leaving FAULT: goes through the filter.
//   - Candidate == current zone: count cleared to 0.
//   - Candidate == pending: count+1; count reaches STABLE_CNT -> commit.
//   - Otherwise: pending=candidate, count=1; commits immediately if STABLE_CNT==1.
//   - Counter saturates and cannot wrap; it is cleared on every commit.
//  Latency:
//   - temp_code, code_valid and zone_change update on the clock edge after the
//     sample_valid cycle that causes a commit (1 cycle).
//   - zone_change=1 for exactly that cycle, only if the new zone != the old zone.
//     The first commit after reset always pulses.
// CONFIGURATION
//  TEMP_ALARM_LATCH_EN defined:
//   - alarm is set on the same edge as any commit to HOT or FAULT.
//   - alarm stays 1 until alarm_clr=1 is sampled while the zone is COLD or NORMAL;
//     it then clears on the next edge.
//   - Set wins over a simultaneous alarm_clr.
//  TEMP_ALARM_LATCH_EN undefined:
//   - alarm and alarm_clr ports are absent; the rest of the block is unchanged.
// TESTING (defaults)
//  1 Reset, then one sample 30 -> next cycle temp_code=01, code_valid=1,
//    zone_change=1 for one cycle.
//  2 From NORMAL, samples 42,42,42,20,42: no change (count restarts at 20);
//    then 42,42,42 -> 11 on the 4th consecutive 42; 41 alone never moves HOT.
//  3 From HOT, sample 255 -> FAULT (10) next cycle, no filter;
//    then 4x 10 -> COLD (00), one zone_change pulse.
//  4 Hysteresis: from COLD, 21 x4 stays 00; 22 x4 -> 01. From NORMAL, 19 x4 stays
//    01; 17 x4 -> 00.
//  5 Assert reset after 3 of 4 qualifying samples toward HOT -> outputs return to
//    reset values at once; the next sample re-classifies from scratch.
//  6 (TEMP_ALARM_LATCH_EN) reach HOT -> alarm=1; alarm_clr while HOT -> alarm stays
//    1; return to NORMAL, alarm_clr -> alarm=0 next cycle.

Source files
------------

// File: rtl/temp_zone_encoder.sv
// temp_zone_encoder: classifies strobed temperature samples into COLD/NORMAL/HOT/FAULT
// with hysteresis and a stability filter. Optional alarm latch: TEMP_ALARM_LATCH_EN. Rev 1.0
`default_nettype none

module temp_zone_encoder #(
  parameter int NBITS      = 8,
  parameter int T_LOW      = 20,
  parameter int T_HIGH     = 40,
  parameter int HYST       = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] temp_in,
  input  logic             sample_valid,
  output logic [1:0]       temp_code,
  output logic             code_valid,
  output logic             zone_change
`ifdef TEMP_ALARM_LATCH_EN
  ,
  output logic             alarm,
  input  logic             alarm_clr
`endif
);

  typedef enum logic [1:0] {
    COLD   = 2'b00,
    NORMAL = 2'b01,
    FAULT  = 2'b10,
    HOT    = 2'b11
  } zone_t;

  localparam int CW = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT);
  localparam logic [NBITS:0] RISE_LO = (NBITS+1)'(T_LOW + HYST);
  localparam logic [NBITS:0] RISE_HI = (NBITS+1)'(T_HIGH + HYST);
  localparam logic [NBITS:0] FALL_LO = (NBITS+1)'(T_LOW - HYST);
  localparam logic [NBITS:0] FALL_HI = (NBITS+1)'(T_HIGH - HYST);
  localparam logic [NBITS:0] BASE_LO = (NBITS+1)'(T_LOW);
  localparam logic [NBITS:0] BASE_HI = (NBITS+1)'(T_HIGH);

  zone_t          zone_q, zone_d, pend_q, pend_d, cand, from;
  logic           valid_q, valid_d, change_q, change_d, commit;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NBITS:0] t;

  // Candidate zone; before the first commit the sample is classified as from FAULT
  always_comb begin
    t    = {1'b0, temp_in};
    from = valid_q ? zone_q : FAULT;
    cand = from;
    if (&temp_in) begin
      cand = FAULT;
    end else begin
      case (from)
        COLD:    cand = (t >= RISE_HI) ? HOT  : (t >= RISE_LO) ? NORMAL : COLD;
        NORMAL:  cand = (t >= RISE_HI) ? HOT  : (t <  FALL_LO) ? COLD   : NORMAL;
        HOT:     cand = (t <  FALL_LO) ? COLD : (t <  FALL_HI) ? NORMAL : HOT;
        default: cand = (t >= BASE_HI) ? HOT  : (t >= BASE_LO) ? NORMAL : COLD;
      endcase
    end
  end

  always_comb begin
    zone_d   = zone_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    commit   = 1'b0;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    if (sample_valid) begin
      if (!valid_q) begin
        commit = 1'b1;
      end else if (cand == zone_q) begin
        cnt_d = '0;
      end else if (cand == FAULT) begin
        commit = 1'b1;
      end else begin
        if (cand == pend_q) begin
          cnt_d = cnt_inc;
        end else begin
          pend_d = cand;
          cnt_d  = CW'(1);
        end
        if (cnt_d >= CNT_MAX) commit = 1'b1;
      end
    end
    if (commit) begin
      zone_d   = cand;
      cnt_d    = '0;
      valid_d  = 1'b1;
      change_d = !valid_q || (cand != zone_q);
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      zone_q   <= COLD;
      pend_q   <= COLD;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      zone_q   <= zone_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      change_q <= change_d;
    end
  end

  assign temp_code   = zone_q;
  assign code_valid  = valid_q;
  assign zone_change = change_q;

`ifdef TEMP_ALARM_LATCH_EN
  // Set has priority; clear only honoured once the zone has left HOT/FAULT
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      alarm <= 1'b0;
    end else if (commit && (cand == HOT || cand == FAULT)) begin
      alarm <= 1'b1;
    end else if (alarm_clr && (zone_q == COLD || zone_q == NORMAL)) begin
      alarm <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_temp_zone_encoder.sv
// Self-checking bench for temp_zone_encoder: scoreboard of expected outputs from a behavioural model.
`default_nettype none

module tb_temp_zone_encoder;

  localparam logic [1:0] Z_COLD = 2'b00, Z_NORM = 2'b01, Z_FAULT = 2'b10, Z_HOT = 2'b11;

  typedef struct packed {
    logic [1:0] code;
    logic       valid;
    logic       change;
    logic       alarm;
  } exp_t;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] temp_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic [1:0] temp_code;
  logic       code_valid, zone_change;
`ifdef TEMP_ALARM_LATCH_EN
  logic       alarm;
  logic       alarm_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [1:0] m_zone = Z_COLD, m_pend = Z_COLD;
  logic       m_valid = 1'b0, m_change = 1'b0, m_alarm = 1'b0;
  int         m_cnt = 0;

  temp_zone_encoder dut (
    .clk_2(clk_2), .reset(reset), .temp_in(temp_in), .sample_valid(sample_valid),
    .temp_code(temp_code), .code_valid(code_valid), .zone_change(zone_change)
`ifdef TEMP_ALARM_LATCH_EN
    , .alarm(alarm), .alarm_clr(alarm_clr)
`endif
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: thresholds written out for the default parameters
  task automatic model_push(input logic sv, input logic [7:0] t, input logic clr);
    logic [1:0] from, c, old;
    bit commit;
    exp_t e;
    commit = 0;
    old    = m_zone;
    c      = m_zone;
    if (sv) begin
      from = m_valid ? m_zone : Z_FAULT;
      if (t == 8'hFF) c = Z_FAULT;
      else if (from == Z_COLD)  c = (t >= 42) ? Z_HOT  : (t >= 22) ? Z_NORM : Z_COLD;
      else if (from == Z_NORM)  c = (t >= 42) ? Z_HOT  : (t < 18)  ? Z_COLD : Z_NORM;
      else if (from == Z_HOT)   c = (t < 18)  ? Z_COLD : (t < 38)  ? Z_NORM : Z_HOT;
      else                      c = (t >= 40) ? Z_HOT  : (t >= 20) ? Z_NORM : Z_COLD;
      if (!m_valid) commit = 1;
      else if (c == m_zone) m_cnt = 0;
      else if (c == Z_FAULT) commit = 1;
      else begin
        if (m_cnt != 0 && c == m_pend) m_cnt++;
        else begin m_pend = c; m_cnt = 1; end
        if (m_cnt >= 4) commit = 1;
      end
    end
    if (commit && (c == Z_HOT || c == Z_FAULT)) m_alarm = 1'b1;
    else if (clr && (old == Z_COLD || old == Z_NORM)) m_alarm = 1'b0;
    if (commit) begin
      m_change = !m_valid || (c != m_zone);
      m_zone   = c;
      m_valid  = 1'b1;
      m_cnt    = 0;
    end else begin
      m_change = 1'b0;
    end
    e.code = m_zone; e.valid = m_valid; e.change = m_change; e.alarm = m_alarm;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic sv, input logic [7:0] t, input logic clr);
    @(negedge clk_2);
    sample_valid = sv;
    temp_in      = t;
`ifdef TEMP_ALARM_LATCH_EN
    alarm_clr    = clr;
`endif
    model_push(sv, t, clr);
    @(posedge clk_2);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_zone = Z_COLD; m_pend = Z_COLD; m_valid = 1'b0; m_change = 1'b0; m_alarm = 1'b0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk_2);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({temp_code, code_valid, zone_change} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got code=%b valid=%b change=%b, want 00/0/0", temp_code, code_valid, zone_change);
    end
`ifdef TEMP_ALARM_LATCH_EN
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
`endif
  endtask

  task automatic test_first_sample();
    logic [8:0] seq[$];
    exp_t e;
    seq = '{9'h100 | 9'd30, 9'd0, 9'd0};
    foreach (seq[i]) begin
      cycle(seq[i][8], seq[i][7:0], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({temp_code, code_valid, zone_change} !== {e.code, e.valid, e.change}) begin
        errors++;
        $display("FAIL first_sample[%0d]: got %b/%b/%b want %b/%b/%b", i, temp_code, code_valid, zone_change, e.code, e.valid, e.change);
      end
      if (i == 0) begin
        checks++;
        if ({temp_code, code_valid, zone_change} !== 4'b0111) begin
          errors++;
          $display("FAIL first_commit_normal: got %b/%b/%b want 01/1/1", temp_code, code_valid, zone_change);
        end
      end
    end
  endtask

  task automatic test_filter();
    logic [7:0] seq[$];
    exp_t e;
    seq = '{41, 41, 41, 41, 41, 42, 42, 42, 20, 42, 42, 42, 42};
    foreach (seq[i]) begin
      cycle(1'b1, seq[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({temp_code, code_valid, zone_change} !== {e.code, e.valid, e.change}) begin
        errors++;
        $display("FAIL filter[%0d] t=%0d: got %b/%b/%b want %b/%b/%b", i, seq[i], temp_code, code_valid, zone_change, e.code, e.valid, e.change);
      end
    end
    checks++;
    if (temp_code !== Z_HOT || zone_change !== 1'b1) begin
      errors++;
      $display("FAIL filter_reach_hot: got code=%b change=%b want 11/1", temp_code, zone_change);
    end
  endtask

  task automatic test_fault();
    logic [7:0] seq[$];
    exp_t e;
    seq = '{255, 10, 10, 10, 10, 10};
    foreach (seq[i]) begin
      cycle(1'b1, seq[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({temp_code, code_valid, zone_change} !== {e.code, e.valid, e.change}) begin
        errors++;
        $display("FAIL fault[%0d] t=%0d: got %b/%b/%b want %b/%b/%b", i, seq[i], temp_code, code_valid, zone_change, e.code, e.valid, e.change);
      end
      if (i == 0 && temp_code !== Z_FAULT) begin
        errors++;
        $display("FAIL fault_immediate: got %b want 10", temp_code);
      end
      if (i == 0) checks++;
    end
    checks++;
    if (temp_code !== Z_COLD) begin errors++; $display("FAIL fault_exit_cold: got %b want 00", temp_code); end
  endtask

  task automatic test_hysteresis();
    logic [7:0] seq[$];
    exp_t e;
    seq = '{21, 21, 21, 21, 22, 22, 22, 22, 19, 19, 19, 19, 17, 17, 17, 17};
    foreach (seq[i]) begin
      cycle(1'b1, seq[i], 1'b0);
      e = sb.pop_front();
      checks++;
      if ({temp_code, code_valid, zone_change} !== {e.code, e.valid, e.change}) begin
        errors++;
        $display("FAIL hyst[%0d] t=%0d: got %b/%b/%b want %b/%b/%b", i, seq[i], temp_code, code_valid, zone_change, e.code, e.valid, e.change);
      end
      if (i == 3 || i == 7 || i == 11 || i == 15) begin
        checks++;
        if (temp_code !== ((i == 3 || i == 15) ? Z_COLD : Z_NORM)) begin
          errors++;
          $display("FAIL hyst_zone[%0d]: got %b", i, temp_code);
        end
      end
    end
  endtask

  task automatic test_reset_midway();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'd50, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({temp_code, zone_change} !== {e.code, e.change}) begin
        errors++;
        $display("FAIL midway_pre[%0d]: got %b/%b want %b/%b", i, temp_code, zone_change, e.code, e.change);
      end
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({temp_code, code_valid, zone_change} !== 4'b0000) begin
      errors++;
      $display("FAIL midway_async_reset: got %b/%b/%b want 00/0/0", temp_code, code_valid, zone_change);
    end
    @(negedge clk_2);
    reset = 1'b1;
    cycle(1'b1, 8'd50, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({temp_code, code_valid, zone_change} !== 4'b1111 || temp_code !== e.code) begin
      errors++;
      $display("FAIL midway_reclassify: got %b/%b/%b want 11/1/1", temp_code, code_valid, zone_change);
    end
  endtask

`ifdef TEMP_ALARM_LATCH_EN
  task automatic test_alarm();
    logic [9:0] seq[$];
    exp_t e;
    // {clr, valid, temp}: HOT already; clr while HOT, go NORMAL, clr
    seq = '{10'h200, 10'h200, 10'h100 | 10'd30, 10'h100 | 10'd30, 10'h100 | 10'd30,
            10'h100 | 10'd30, 10'h200, 10'h000};
    foreach (seq[i]) begin
      cycle(seq[i][8], seq[i][7:0], seq[i][9]);
      e = sb.pop_front();
      checks++;
      if ({temp_code, alarm} !== {e.code, e.alarm}) begin
        errors++;
        $display("FAIL alarm[%0d]: got code=%b alarm=%b want %b/%b", i, temp_code, alarm, e.code, e.alarm);
      end
    end
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_cleared: got %b want 0", alarm); end
  endtask
`endif

  task automatic test_random();
    exp_t e;
    logic sv, clr;
    logic [7:0] t;
    for (int i = 0; i < 400; i++) begin
      sv  = ($urandom_range(0, 3) != 0);
      t   = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(10, 50));
      clr = ($urandom_range(0, 7) == 0);
      cycle(sv, t, clr);
      e = sb.pop_front();
      checks++;
      if ({temp_code, code_valid, zone_change} !== {e.code, e.valid, e.change}
`ifdef TEMP_ALARM_LATCH_EN
          || alarm !== e.alarm
`endif
         ) begin
        errors++;
        $display("FAIL random[%0d] sv=%b t=%0d: got %b/%b/%b want %b/%b/%b", i, sv, t, temp_code, code_valid, zone_change, e.code, e.valid, e.change);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_filter();
`ifdef TEMP_ALARM_LATCH_EN
    test_alarm();
`endif
    test_fault();
    test_hysteresis();
    test_reset_midway();
    test_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
